// File: rtl/branch_comp.sv
// RV32I branch comparator: combinational EQ/LT/LTU flags, funct3 branch decision, registered copy.
// Optional BRANCH_COMP_ILLEGAL_CHK_EN adds ILLEGAL_Q flagging valid branches with reserved funct3.
module branch_comp #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] IN_1,
  input  logic [XLEN-1:0] IN_2,
  input  logic [2:0]      FUNCT3,
  input  logic            BR_VALID,
  output logic            EQUEL,
  output logic            LT,
  output logic            LTU,
  output logic            TAKEN,
  output logic            TAKEN_Q,
`ifdef BRANCH_COMP_ILLEGAL_CHK_EN
  output logic            ILLEGAL_Q,
`endif
  output logic            VALID_Q
);

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_RSV2 = 3'b010,
    BR_RSV3 = 3'b011,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_t;

  logic raw_decision;

  assign EQUEL = (IN_1 == IN_2);
  assign LT    = ($signed(IN_1) < $signed(IN_2));
  assign LTU   = (IN_1 < IN_2);

  always_comb begin
    raw_decision = 1'b0;
    case (branch_t'(FUNCT3))
      BR_BEQ:  raw_decision = EQUEL;
      BR_BNE:  raw_decision = ~EQUEL;
      BR_BLT:  raw_decision = LT;
      BR_BGE:  raw_decision = ~LT;
      BR_BLTU: raw_decision = LTU;
      BR_BGEU: raw_decision = ~LTU;
      default: raw_decision = 1'b0;
    endcase
  end

  assign TAKEN = BR_VALID & raw_decision;

  always_ff @(posedge CLK) begin
    if (RST) begin
      TAKEN_Q <= 1'b0;
      VALID_Q <= 1'b0;
    end else begin
      TAKEN_Q <= TAKEN;
      VALID_Q <= BR_VALID;
    end
  end

`ifdef BRANCH_COMP_ILLEGAL_CHK_EN
  // Reserved encodings 010/011 share the pattern 01x.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ILLEGAL_Q <= 1'b0;
    end else begin
      ILLEGAL_Q <= BR_VALID & (FUNCT3[2:1] == 2'b01);
    end
  end
`endif

endmodule

// File: tb/tb_branch_comp.sv
// Directed self-checking bench for branch_comp; expected values are hand-computed per vector.
module tb_branch_comp;

  logic        CLK;
  logic        RST;
  logic [31:0] IN_1;
  logic [31:0] IN_2;
  logic [2:0]  FUNCT3;
  logic        BR_VALID;
  logic        EQUEL;
  logic        LT;
  logic        LTU;
  logic        TAKEN;
  logic        TAKEN_Q;
  logic        VALID_Q;
`ifdef BRANCH_COMP_ILLEGAL_CHK_EN
  logic        ILLEGAL_Q;
`endif

  bit clkRun = 1'b0;
  int numCompared = 0;
  int numMismatched = 0;

  branch_comp #(.XLEN(32)) dut (
    .CLK(CLK),
    .RST(RST),
    .IN_1(IN_1),
    .IN_2(IN_2),
    .FUNCT3(FUNCT3),
    .BR_VALID(BR_VALID),
    .EQUEL(EQUEL),
    .LT(LT),
    .LTU(LTU),
    .TAKEN(TAKEN),
    .TAKEN_Q(TAKEN_Q),
`ifdef BRANCH_COMP_ILLEGAL_CHK_EN
    .ILLEGAL_Q(ILLEGAL_Q),
`endif
    .VALID_Q(VALID_Q)
  );

  // Clock only toggles once clkRun is set, so the first checks run with no clock at all.
  initial CLK = 1'b0;
  always begin
    #5;
    if (clkRun) CLK = ~CLK;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numCompared++;
    if (got !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] f, input logic v);
    IN_1 = a;
    IN_2 = b;
    FUNCT3 = f;
    BR_VALID = v;
    #1;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    applyStimulus(32'h0, 32'h0, 3'b000, 1'b0);

    // Combinational flags with the clock stopped
    checkOutput("eq_zero_noclk", 32'(EQUEL), 32'd1);
    checkOutput("lt_zero_noclk", 32'(LT), 32'd0);
    checkOutput("ltu_zero_noclk", 32'(LTU), 32'd0);
    applyStimulus(32'h0, 32'h0, 3'b000, 1'b1);
    checkOutput("taken_beq_noclk", 32'(TAKEN), 32'd1);

    // Reset holds registered outputs low even while TAKEN is high
    clkRun = 1'b1;
    tick();
    checkOutput("reset_taken_q", 32'(TAKEN_Q), 32'd0);
    checkOutput("reset_valid_q", 32'(VALID_Q), 32'd0);
    RST = 1'b0;

    applyStimulus(32'h00001001, 32'h00001001, 3'b000, 1'b0);
    checkOutput("eq_1001", 32'(EQUEL), 32'd1);
    #10;
    IN_1 = 32'h00001011;
    #1;
    checkOutput("eq_1011", 32'(EQUEL), 32'd0);
    checkOutput("lt_1011", 32'(LT), 32'd0);
    checkOutput("ltu_1011", 32'(LTU), 32'd0);

    // Most negative vs most positive
    applyStimulus(32'h80000000, 32'h7FFFFFFF, 3'b100, 1'b1);
    checkOutput("lt_min_max", 32'(LT), 32'd1);
    checkOutput("ltu_min_max", 32'(LTU), 32'd0);
    checkOutput("taken_blt_min_max", 32'(TAKEN), 32'd1);
    tick();
    checkOutput("taken_q_blt", 32'(TAKEN_Q), 32'd1);
    checkOutput("valid_q_blt", 32'(VALID_Q), 32'd1);
    applyStimulus(32'h80000000, 32'h7FFFFFFF, 3'b110, 1'b1);
    checkOutput("taken_bltu_min_max", 32'(TAKEN), 32'd0);
    tick();
    checkOutput("taken_q_bltu", 32'(TAKEN_Q), 32'd0);

    // -1 vs 0 and the reverse
    applyStimulus(32'hFFFFFFFF, 32'h00000000, 3'b111, 1'b1);
    checkOutput("lt_m1_0", 32'(LT), 32'd1);
    checkOutput("ltu_m1_0", 32'(LTU), 32'd0);
    checkOutput("taken_bgeu_m1_0", 32'(TAKEN), 32'd1);
    applyStimulus(32'hFFFFFFFF, 32'h00000000, 3'b101, 1'b1);
    checkOutput("taken_bge_m1_0", 32'(TAKEN), 32'd0);
    applyStimulus(32'h00000000, 32'hFFFFFFFF, 3'b110, 1'b1);
    checkOutput("lt_0_m1", 32'(LT), 32'd0);
    checkOutput("ltu_0_m1", 32'(LTU), 32'd1);
    checkOutput("taken_bltu_0_m1", 32'(TAKEN), 32'd1);

    // Equal operands across the decision table
    applyStimulus(32'h12345678, 32'h12345678, 3'b001, 1'b1);
    checkOutput("taken_bne_eq", 32'(TAKEN), 32'd0);
    applyStimulus(32'h12345678, 32'h12345678, 3'b101, 1'b1);
    checkOutput("taken_bge_eq", 32'(TAKEN), 32'd1);
    applyStimulus(32'h12345678, 32'h12345678, 3'b111, 1'b1);
    checkOutput("taken_bgeu_eq", 32'(TAKEN), 32'd1);
    applyStimulus(32'h12345678, 32'h12345678, 3'b110, 1'b1);
    checkOutput("taken_bltu_eq", 32'(TAKEN), 32'd0);
    applyStimulus(32'h12345678, 32'h12345678, 3'b100, 1'b1);
    checkOutput("taken_blt_eq", 32'(TAKEN), 32'd0);
    applyStimulus(32'h12345678, 32'h12345679, 3'b000, 1'b1);
    checkOutput("taken_beq_ne", 32'(TAKEN), 32'd0);
    applyStimulus(32'h12345678, 32'h12345679, 3'b001, 1'b1);
    checkOutput("taken_bne_ne", 32'(TAKEN), 32'd1);
    applyStimulus(32'h12345678, 32'h12345678, 3'b000, 1'b0);
    checkOutput("taken_novalid", 32'(TAKEN), 32'd0);
    tick();
    checkOutput("valid_q_novalid", 32'(VALID_Q), 32'd0);
    checkOutput("taken_q_novalid", 32'(TAKEN_Q), 32'd0);

    // Reserved encodings never take
    applyStimulus(32'h0, 32'h0, 3'b010, 1'b1);
    checkOutput("taken_rsv010", 32'(TAKEN), 32'd0);
`ifdef BRANCH_COMP_ILLEGAL_CHK_EN
    tick();
    checkOutput("illegal_q_010", 32'(ILLEGAL_Q), 32'd1);
`endif
    applyStimulus(32'h0, 32'h1, 3'b011, 1'b1);
    checkOutput("taken_rsv011", 32'(TAKEN), 32'd0);
`ifdef BRANCH_COMP_ILLEGAL_CHK_EN
    tick();
    checkOutput("illegal_q_011", 32'(ILLEGAL_Q), 32'd1);
    applyStimulus(32'h0, 32'h0, 3'b000, 1'b1);
    tick();
    checkOutput("illegal_q_000", 32'(ILLEGAL_Q), 32'd0);
`endif

    // Mid-stream reset clears registered outputs on that edge only
    applyStimulus(32'h00000005, 32'h0000000A, 3'b100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("taken_q_stream%0d", i), 32'(TAKEN_Q), 32'd1);
    end
    RST = 1'b1;
    tick();
    checkOutput("taken_q_midrst", 32'(TAKEN_Q), 32'd0);
    checkOutput("valid_q_midrst", 32'(VALID_Q), 32'd0);
    checkOutput("eq_midrst", 32'(EQUEL), 32'd0);
    checkOutput("lt_midrst", 32'(LT), 32'd1);
    checkOutput("ltu_midrst", 32'(LTU), 32'd1);
    checkOutput("taken_midrst", 32'(TAKEN), 32'd1);
    RST = 1'b0;
    tick();
    checkOutput("taken_q_postrst", 32'(TAKEN_Q), 32'd1);
    checkOutput("valid_q_postrst", 32'(VALID_Q), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/branch_comp.md
Name: branch_comp

Overview:
- RV32I branch comparator for the execute stage of the RISC_V core.
- Compares two 32-bit register operands and drives equality and less-than flags combinationally.
- Decodes the branch funct3 into a taken/not-taken decision.
- Also provides a registered copy of the decision for the PC-select pipeline stage.

Parameters:
- XLEN, 32: operand width; all comparisons are performed at this width.

Ports:
- CLK  input  1  single clock; all sequential logic uses the rising edge.
- RST  input  1  reset, synchronous and active-high.
- IN_1  input  XLEN  operand rs1.
- IN_2  input  XLEN  operand rs2.
- FUNCT3  input  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- BR_VALID  input  1  a branch instruction is present this cycle.
- EQUEL  output  1  combinational: IN_1 == IN_2.
- LT  output  1  combinational: signed IN_1 < IN_2.
- LTU  output  1  combinational: unsigned IN_1 < IN_2.
- TAKEN  output  1  combinational branch decision; qualified by BR_VALID.
- TAKEN_Q  output  1  TAKEN registered on CLK.
- VALID_Q  output  1  BR_VALID registered on CLK.

Behaviour:
- Combinational flags:
  - EQUEL, LT and LTU depend only on IN_1 and IN_2, with no clock dependency and no latency.
  - They are valid within the same delta after the inputs change, even if CLK never toggles and RST is held at any value.
  - LT compares two's-complement values. LTU compares unsigned values. Both are computed at full XLEN width, with no overflow artefacts.
- Decision:
  - Raw decision by FUNCT3: BEQ=EQUEL, BNE=!EQUEL, BLT=LT, BGE=!LT, BLTU=LTU, BGEU=!LTU.
  - Reserved FUNCT3 values 010 and 011 give raw decision 0.
  - TAKEN = BR_VALID & raw decision.
- Registered path:
  - At each rising CLK edge with RST=1: TAKEN_Q<=0 and VALID_Q<=0.
  - At each rising CLK edge with RST=0: TAKEN_Q<=TAKEN and VALID_Q<=BR_VALID.
  - Latency is exactly 1 cycle.
  - Asserting RST mid-stream clears both registered outputs on that edge only. Combinational outputs are unaffected by RST.
- Boundaries:
  - Equal operands give LT=0, LTU=0, EQUEL=1.
  - Operands 0x80000000 vs 0x7FFFFFFF give LT=1, LTU=0.
  - Operands 0xFFFFFFFF vs 0x00000000 give LT=1, LTU=0.
- There are no X-propagation requirements beyond standard synthesizable RTL.

Optional Feature:
- Macro name: BRANCH_COMP_ILLEGAL_CHK_EN.
- When defined:
  - Adds output ILLEGAL_Q (1 bit).
  - On each rising CLK edge, ILLEGAL_Q <= BR_VALID & (FUNCT3 is 010 or 011).
  - RST clears ILLEGAL_Q.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- IN_1=0, IN_2=0 -> EQUEL=1, LT=0, LTU=0, with no clock running.
- IN_1=0x00001001, IN_2=0x00001001, then after 10 ns IN_1=0x00001011 -> EQUEL=1, then EQUEL=0 and LT=0, LTU=0.
- IN_1=0x80000000, IN_2=0x7FFFFFFF, BR_VALID=1, FUNCT3=100 (BLT) -> TAKEN=1, TAKEN_Q=1 after one edge. With FUNCT3=110 (BLTU) -> TAKEN=0.
- Equal operands, BR_VALID=1, FUNCT3=001 (BNE) -> TAKEN=0. FUNCT3=101 (BGE) -> TAKEN=1. BR_VALID=0 -> TAKEN=0, VALID_Q=0 next cycle.
- Drive TAKEN=1 for several cycles, then RST=1 for one edge -> TAKEN_Q=0 and VALID_Q=0 on that edge, while EQUEL/LT/LTU are unchanged.
- With BRANCH_COMP_ILLEGAL_CHK_EN defined: FUNCT3=010, BR_VALID=1 -> TAKEN=0, ILLEGAL_Q=1 next cycle. FUNCT3=000 -> ILLEGAL_Q=0.
